mips_register_file: RTL and testbench



---
 rtl/mips_register_file.sv | 69 ++++++
 tb/tb_mips_register_file.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two comb read ports,
// one sync write port, $zero hardwired, optional write bypass.
module mips_register_file #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter bit                BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] SP_RESET = 'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG   = 2**ADDR_W;
  localparam int unsigned SP_IDX = 29;

  // Register 0 has no storage; index range starts at 1.
  logic [DATA_W-1:0] regs_q [1:NREG-1];

  logic wr_fire_d;
  logic byp_a_d;
  logic byp_b_d;

  assign wr_fire_d = wr_en && (wr_addr != '0);

  function automatic logic [DATA_W-1:0] stored(
    input logic [ADDR_W-1:0] a
  );
    if (a == '0) return '0;
    return regs_q[a];
  endfunction

  // Commit write-back; reset clears all but $sp and beats a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wr_fire_d) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Forward the in-flight write to a matching read port.
  always_comb begin
    byp_a_d = 1'b0;
    byp_b_d = 1'b0;
    if (BYPASS && wr_fire_d && !rst) begin
      byp_a_d = (wr_addr == rd_addr_a);
      byp_b_d = (wr_addr == rd_addr_b);
    end
  end

  // Read muxes; debug port always sees committed storage.
  always_comb begin
    rd_data_a = byp_a_d ? wr_data : stored(rd_addr_a);
    rd_data_b = byp_b_d ? wr_data : stored(rd_addr_b);
    dbg_data  = stored(dbg_addr);
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: BYPASS=1 and
// BYPASS=0 instances checked against an array model.
module tb_mips_register_file;

  localparam logic [31:0] SP = 32'h0000_0FFC;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  dbg_addr;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] dbg_data;
  logic [31:0] rd_data_a0;
  logic [31:0] rd_data_b0;
  logic [31:0] dbg_data0;

  mips_register_file #(.BYPASS(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  mips_register_file #(.BYPASS(1'b0)) dut_nb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a0),
    .rd_data_b (rd_data_b0),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data0)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [31:0] a0;
    logic [31:0] b0;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   total;
  int   bad;

  logic [31:0] model [32];

  function automatic void model_reset();
    foreach (model[i]) model[i] = 32'h0;
    model[29] = SP;
  endfunction

  function automatic logic [31:0] mread(
    input logic [4:0] a,
    input bit         byp
  );
    if (a == 5'd0) return 32'h0;
    if (byp && wr_en && !rst && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  function automatic void chk(
    input string       tag,
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h exp=%h", tag, nm, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per sample event.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "rd_a",    rd_data_a,  e.a);
        chk(e.tag, "rd_b",    rd_data_b,  e.b);
        chk(e.tag, "dbg",     dbg_data,   e.d);
        chk(e.tag, "nb_rd_a", rd_data_a0, e.a0);
        chk(e.tag, "nb_rd_b", rd_data_b0, e.b0);
        chk(e.tag, "nb_dbg",  dbg_data0,  e.d);
      end
    end
  end

  task automatic expect_now(input string tag);
    exp_t e;
    e.a   = mread(rd_addr_a, 1'b1);
    e.b   = mread(rd_addr_b, 1'b1);
    e.d   = mread(dbg_addr,  1'b0);
    e.a0  = mread(rd_addr_a, 1'b0);
    e.b0  = mread(rd_addr_b, 1'b0);
    e.tag = tag;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic step(
    input bit          r,
    input bit          we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  ra,
    input logic [4:0]  rb,
    input logic [4:0]  da,
    input string       tag
  );
    rst       = r;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    dbg_addr  = da;
    if (r) model_reset();
    #1;
    expect_now(tag);
    @(posedge clk);
    if (wr_en && !rst && wr_addr != 5'd0) model[wr_addr] = wr_data;
    #1;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [4:0] wa;
    logic [4:0] ra;
    logic [4:0] rb;
    total     = 0;
    bad       = 0;
    clk_run   = 1'b0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'h0;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    dbg_addr  = 5'd0;
    model_reset();

    // reset contents, no clock edges yet
    for (int i = 0; i < 32; i++) begin
      dbg_addr  = 5'(i);
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      expect_now("reset");
    end

    clk_run = 1'b1;
    step(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd29, 5'd3, "rst_wr");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd29, 5'd29, "rst_rel");

    // basic write/read
    step(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8, "wr8");
    step(1'b0, 1'b1, 5'd9, 32'h0000_0005, 5'd1, 5'd2, 5'd8, "wr9");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd9, "rd89");

    // $zero
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "wr0");
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'(i), "zsweep");
    end

    // bypass vs stored value
    step(1'b0, 1'b1, 5'd10, 32'h1111_1111, 5'd0, 5'd0, 5'd10, "wr10");
    step(1'b0, 1'b1, 5'd10, 32'h1234_5678, 5'd10, 5'd10, 5'd10, "byp");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 5'd10, "post_byp");

    // reset beats write, async clear mid-cycle
    step(1'b0, 1'b1, 5'd12, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0, "wr12");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd12, "rd12");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    expect_now("async_rst");
    step(1'b1, 1'b1, 5'd12, 32'h7, 5'd12, 5'd29, 5'd12, "rst_hold");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd29, 5'd12, "rst_won");

    // random regression
    for (int n = 0; n < 10000; n++) begin
      wa = raddr();
      ra = ($urandom_range(0, 3) == 0) ? wa : raddr();
      rb = ($urandom_range(0, 3) == 0) ? wa : raddr();
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 3) != 0),
           wa, $urandom, ra, rb, raddr(), "rand");
    end

    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
